// File: rtl/adder4_seq_arbiter_if.sv
// Request/response bundle for the shared nibble-serial adder.
// Two requesters plus one result channel, all valid/ready.
interface adder4_seq_arbiter_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );
endinterface

// File: rtl/adder4_seq_arbiter.sv
// Round-robin share of one external 4-bit adder, sequenced
// nibble by nibble to build a 4*NIBBLES-bit add with carry chain.
module adder4_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder4_seq_arbiter_if.slave  bus,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 busy
);
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [NIBBLES-1:0][3:0] a_reg;
    logic [NIBBLES-1:0][3:0] b_reg;
    logic [NIBBLES-1:0][3:0] sum_reg;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic                    last_grant;
    logic                    rsp_valid_q;
    logic                    rsp_id_q;
    logic                    rsp_cout_q;

    logic gnt0, gnt1, accept, last_nib, rsp_hs;

    // req1 wins only when req0 is idle or req0 was served last
    assign gnt1     = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign gnt0     = bus.req0_valid & ~gnt1;
    assign accept   = (state == IDLE) & (gnt0 | gnt1);
    assign last_nib = (idx == IW'(NIBBLES - 1));
    assign rsp_hs   = rsp_valid_q & bus.rsp_ready;

    assign bus.req0_ready = (state == IDLE) & gnt0;
    assign bus.req1_ready = (state == IDLE) & gnt1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = sum_reg;
    assign bus.rsp_cout   = rsp_cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last_nib ? DONE : RUN;
            DONE:    state_nx = rsp_hs ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        busy    = (state != IDLE);
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg    <= gnt1 ? bus.req1_a : bus.req0_a;
                        b_reg    <= gnt1 ? bus.req1_b : bus.req0_b;
                        carry    <= gnt1 ? bus.req1_cin : bus.req0_cin;
                        rsp_id_q <= gnt1;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= add_sum;
                    carry        <= add_cout;
                    idx          <= idx + 1'b1;
                    if (last_nib) begin
                        idx         <= '0;
                        rsp_cout_q  <= add_cout;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        last_grant  <= rsp_id_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
